mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit bridging core byte/half/word requests to a big-endian word memory
module mem_access_unit #(
  parameter int MEM_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wenable,
  output logic        mem_renable,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

  localparam logic [31:0] LAST_BASE = 32'(MEM_BYTES - 4);
  localparam logic [32:0] MEM_END   = 33'(MEM_BYTES);

  state_t      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [31:0] mem_addr_q;
  logic        mem_wenable_q;
  logic        mem_renable_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic [2:0]  nbytes_d;
  logic [32:0] end_d;
  logic        err_d;
  logic [31:0] base_d;
  logic [1:0]  lane_d;
  logic [4:0]  shift_d;
  logic [31:0] aligned_d;
  logic [31:0] load_d;
  logic [31:0] lane_mask_d;
  logic [31:0] insert_d;
  logic [31:0] merge_d;
  logic        accept_d;

  assign accept_d = req_valid && req_ready_q && (state_q == IDLE);

  // Bounds check is done in 33 bits so an address near 2^32 cannot wrap into range.
  always_comb begin
    nbytes_d = 3'd4;
    if (req_size == 2'b00) nbytes_d = 3'd1;
    else if (req_size == 2'b01) nbytes_d = 3'd2;
    end_d  = {1'b0, req_addr} + {30'b0, nbytes_d};
    err_d  = (req_size == 2'b11) || (end_d > MEM_END);
    base_d = (req_addr < LAST_BASE) ? req_addr : LAST_BASE;
    lane_d = req_addr[1:0] - base_d[1:0];
  end

  // Lane k sits k bytes below the top of the big-endian word; shifting left aligns it to the top.
  always_comb begin
    shift_d   = {lane_q, 3'b000};
    aligned_d = mem_rdata << shift_d;
    load_d    = mem_rdata;
    if (size_q == 2'b00)
      load_d = {{24{signed_q & aligned_d[31]}}, aligned_d[31:24]};
    else if (size_q == 2'b01)
      load_d = {{16{signed_q & aligned_d[31]}}, aligned_d[31:16]};
    lane_mask_d = ((size_q == 2'b00) ? 32'hFF00_0000 : 32'hFFFF_0000) >> shift_d;
    insert_d    = ((size_q == 2'b00) ? {wdata_q[7:0], 24'b0} : {wdata_q[15:0], 16'b0}) >> shift_d;
    merge_d     = (mem_rdata & ~lane_mask_d) | insert_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'b0;
      resp_err_q    <= 1'b0;
      mem_addr_q    <= 32'b0;
      mem_wenable_q <= 1'b0;
      mem_renable_q <= 1'b0;
      we_q          <= 1'b0;
      size_q        <= 2'b0;
      signed_q      <= 1'b0;
      lane_q        <= 2'b0;
      wdata_q       <= 32'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= !accept_d;
          if (accept_d) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            lane_q   <= lane_d;
            wdata_q  <= req_wdata;
            if (err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'b0;
            end else if (req_we && req_size == 2'b10) begin
              state_q       <= WRITE;
              mem_wenable_q <= 1'b1;
              mem_addr_q    <= req_addr;
            end else begin
              state_q       <= READ;
              mem_renable_q <= 1'b1;
              mem_addr_q    <= base_d;
            end
          end
        end
        READ: begin
          state_q       <= MERGE;
          mem_renable_q <= 1'b0;
          mem_wenable_q <= we_q;
          if (!we_q) mem_addr_q <= 32'b0;
        end
        MERGE: begin
          state_q       <= RESP;
          mem_wenable_q <= 1'b0;
          mem_addr_q    <= 32'b0;
          resp_valid_q  <= 1'b1;
          resp_err_q    <= 1'b0;
          resp_rdata_q  <= we_q ? 32'b0 : load_d;
        end
        WRITE: begin
          state_q       <= RESP;
          mem_wenable_q <= 1'b0;
          mem_addr_q    <= 32'b0;
          resp_valid_q  <= 1'b1;
          resp_err_q    <= 1'b0;
          resp_rdata_q  <= 32'b0;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q       <= IDLE;
          mem_wenable_q <= 1'b0;
          mem_renable_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wenable = mem_wenable_q;
  assign mem_renable = mem_renable_q;
  // Merged store data depends on the read word that only arrives during MERGE.
  assign mem_wdata   = !mem_wenable_q ? 32'b0 : ((state_q == MERGE) ? merge_d : wdata_q);

endmodule
